mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Sequencing controller and register file for the multiply/divide unit in the E stage of the five-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and computes the products and quotients.
- Holds the result through a configurable busy window, then commits it to HI/LO.
- Exports start and busy, which the stall unit uses to hold MDU-class instructions in D.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (must be at least 1).
- DIV_CYCLES, 10: busy cycles for div/divu (must be at least 1).
- CNT_W, 4: counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid  in  1  E-stage instruction is an MDU-class op (md/mt/mf type).
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- flush  in  1  abort any in-flight operation (exception/cancel path).
- start  out  1  combinational: valid & !busy & op<=3.
- busy  out  1  registered: operation in flight.
- rdata  out  32  combinational: HI when op==6, LO when op==7, otherwise 0.
- HI  out  32  current HI register.
- LO  out  32  current LO register.

Behaviour:
- Reset (reset low, asynchronous): HI=0, LO=0, busy=0, counter=0, pending result=0, state IDLE. Takes effect immediately, including mid-operation.
- States:
  - IDLE (busy=0).
  - RUN (busy=1).
- IDLE -> RUN: at a posedge with start=1.
  - Latch the op class.
  - Compute the 64-bit result from A and B into a pending register {pH, pL}.
  - Load counter with MULT_CYCLES for ops 0-1, DIV_CYCLES for ops 2-3.
- RUN:
  - Counter decrements each posedge.
  - At the posedge where counter==1: HI<=pH, LO<=pL, busy<=0, go to IDLE.
  - busy is high for exactly N cycles after the start edge.
  - New values are visible on HI/LO/rdata in the cycle after busy falls.
- mthi/mtlo: at a posedge with valid & !busy & op 4/5, HI<=A (mthi) or LO<=A (mtlo). One-cycle latency, no busy.
- mfhi/mflo: pure combinational read, no state change.
- Any valid op while busy=1: ignored. The stall unit guarantees none arrive; if one does, it has no effect on state. Asserting this in the bench is required.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=upper 32 bits, LO=lower 32 bits.
  - multu: unsigned 32x32 to 64; same HI/LO split.
  - div: LO=quotient truncated toward zero; HI=remainder carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
  - Divide by zero (B==0): full DIV_CYCLES busy window still taken; HI/LO left unchanged at commit.
- flush:
  - Highest priority over start and mt writes at the same edge.
  - In RUN: busy<=0, counter<=0, no commit; HI/LO keep their pre-op values.
  - In IDLE: suppresses that cycle's start or mt write.
- Back-to-back: start in the cycle right after the commit edge is accepted (busy=0 then). Result of op N+1 sees no hazard from op N's operands, because they were latched.
- start is not registered; consumers sample it on the same edge as the controller.

Test Plan:
- Reset mid-run: mult in progress, pull reset low asynchronously -> HI=LO=0 and busy=0 immediately, before the next clock edge.
- mult, A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div, A=-7, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu, A=7, B=0 after mthi 0x11 and mtlo 0x22 -> after 10 busy cycles HI=0x11, LO=0x22. Signed div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0xDEADBEEF, then mfhi next cycle -> rdata=0xDEADBEEF. mtlo 0x1234 followed immediately by mflo -> rdata=0x1234.
- div started, then flush asserted on busy cycle 4 -> busy drops next edge and HI/LO hold prior values. Flush in the same cycle as start -> no busy and no state change.
- mult held valid while busy, with a second op (mthi 0x55) issued during busy -> no state change. Commit edge followed by a new mult the next cycle -> accepted, busy re-asserts for 5 cycles with the correct second result.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller and HI/LO register file for the E stage.
// The result is computed at the start edge, held through a busy window and then committed.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        start,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        state_dbg
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [31:0]      p_hi, p_lo;
    logic             p_skip;
    logic [31:0]      hi_q, lo_q;

    logic        mt_write;
    logic        is_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] uq, ur, quo, rem;
    logic [63:0] prod_s, prod_u;
    logic [63:0] result;
    logic        div_zero;

    // Arithmetic: ops 0/2 are signed, 1/3 unsigned; division works on magnitudes
    // so that truncation toward zero and the 0x80000000 / -1 case fall out naturally.
    always_comb begin
        is_signed = ~op[0];
        prod_s    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u    = {32'd0, A} * {32'd0, B};
        a_neg     = is_signed & A[31];
        b_neg     = is_signed & B[31];
        a_mag     = a_neg ? (32'd0 - A) : A;
        b_mag     = b_neg ? (32'd0 - B) : B;
        b_safe    = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq        = a_mag / b_safe;
        ur        = a_mag % b_safe;
        quo       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem       = a_neg ? (32'd0 - ur) : ur;
        div_zero  = op[1] & (B == 32'd0);
        if (op[1]) begin
            result = {rem, quo};
        end else if (op[0]) begin
            result = prod_u;
        end else begin
            result = prod_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over both start and commit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush || cnt == CNT_ONE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state == RUN);
        start     = valid & (state == IDLE) & ~op[2];
        mt_write  = valid & (state == IDLE) & (op == 3'd4 || op == 3'd5);
        state_dbg = state;
        HI        = hi_q;
        LO        = lo_q;
        case (op)
            3'd6:    rdata = hi_q;
            3'd7:    rdata = lo_q;
            default: rdata = 32'd0;
        endcase
    end

    // Counter, pending result and HI/LO; ops arriving while busy fall through untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            p_hi   <= 32'd0;
            p_lo   <= 32'd0;
            p_skip <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush) begin
                        if (start) begin
                            cnt    <= op[1] ? DIV_LOAD : MULT_LOAD;
                            p_hi   <= result[63:32];
                            p_lo   <= result[31:0];
                            p_skip <= div_zero;
                        end else if (mt_write) begin
                            if (op == 3'd4) begin
                                hi_q <= A;
                            end else begin
                                lo_q <= A;
                            end
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE && !p_skip) begin
                            hi_q <= p_hi;
                            lo_q <= p_lo;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected {HI,LO} pairs are queued at issue and
// popped when the busy window closes.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] a_in, b_in;
    logic        flush;
    logic        start, busy, state_dbg;
    logic [31:0] rdata, hi, lo;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .A(a_in), .B(b_in),
        .flush(flush), .start(start), .busy(busy), .rdata(rdata),
        .HI(hi), .LO(lo), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: issues a mult/div, counts busy cycles, then checks the commit.
    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int cycles,
                          input bit hold);
        logic [63:0] pre;
        logic [63:0] want;
        int count;
        pre   = {hi, lo};
        valid = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        #1 chk({tag, " start"}, start, 1);
        exp_q.push_back(exp);
        @(negedge clk);
        if (!hold) valid = 1'b0;
        count = 0;
        while (busy === 1'b1 && count < cycles + 5) begin
            chk({tag, " hilo during busy"}, {hi, lo}, pre);
            chk({tag, " start during busy"}, start, 0);
            count++;
            if (hold && count == 2) begin
                op   = 3'd4;
                a_in = 32'h55;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        chk({tag, " busy cycles"}, count, cycles);
        want = exp_q.pop_front();
        chk({tag, " result"}, {hi, lo}, want);
    endtask

    task automatic do_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
        valid = 1'b1;
        op    = o;
        a_in  = a;
        @(negedge clk);
        valid = 1'b0;
        chk(tag, (o == 3'd4) ? hi : lo, a);
    endtask

    initial begin
        logic [63:0] pre;
        logic [31:0] ra, rb;
        int sa, sb;
        longint sp;
        longint unsigned ua, ub;

        reset = 1'b0; valid = 1'b0; flush = 1'b0; op = 3'd0; a_in = 32'd0; b_in = 32'd0;
        #1;
        chk("reset HI", hi, 0);
        chk("reset LO", lo, 0);
        chk("reset busy", busy, 0);
        chk("reset state", state_dbg, 0);
        chk("reset start", start, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_md("mult -2*3", 3'd0, 32'hFFFFFFFE, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFA}, 5, 0);
        run_md("multu", 3'd1, 32'hFFFFFFFE, 32'd3, {32'h00000002, 32'hFFFFFFFA}, 5, 0);
        @(negedge clk);
        run_md("div -7/2", 3'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 10, 0);

        @(negedge clk);
        do_mt("mthi 0x11", 3'd4, 32'h11);
        do_mt("mtlo 0x22", 3'd5, 32'h22);
        run_md("divu by zero", 3'd3, 32'd7, 32'd0, {32'h11, 32'h22}, 10, 0);
        run_md("div overflow", 3'd2, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 10, 0);

        @(negedge clk);
        do_mt("mthi deadbeef", 3'd4, 32'hDEADBEEF);
        valid = 1'b1; op = 3'd6;
        #1 chk("mfhi rdata", rdata, 32'hDEADBEEF);
        chk("mfhi no start", start, 0);
        @(negedge clk);
        do_mt("mtlo 0x1234", 3'd5, 32'h1234);
        valid = 1'b1; op = 3'd7;
        #1 chk("mflo rdata", rdata, 32'h1234);
        op = 3'd0; valid = 1'b0;
        #1 chk("rdata other op", rdata, 0);
        @(negedge clk);

        // Flush on the fourth busy cycle of a div
        pre = {hi, lo};
        valid = 1'b1; op = 3'd2; a_in = 32'd100; b_in = 32'd7;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush busy before", busy, 1);
        chk("flush state before", state_dbg, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy drop", busy, 0);
        chk("flush hilo kept", {hi, lo}, pre);
        repeat (12) @(negedge clk);
        chk("flush no late commit", {hi, lo}, pre);

        // Flush coincident with start and with an mt write
        valid = 1'b1; op = 3'd0; a_in = 32'd3; b_in = 32'd4; flush = 1'b1;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        chk("flush+start busy", busy, 0);
        repeat (6) @(negedge clk);
        chk("flush+start hilo", {hi, lo}, pre);
        valid = 1'b1; op = 3'd4; a_in = 32'h99; flush = 1'b1;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        chk("flush+mthi", hi, pre[63:32]);

        // Op held valid during busy plus a stray mthi, then a back-to-back mult
        run_md("mult held", 3'd0, 32'd6, 32'd7, {32'h0, 32'h2A}, 5, 1);
        run_md("mult b2b", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'h0, 32'h1}, 5, 0);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            sa = ra; sb = rb;
            sp = longint'(sa) * longint'(sb);
            run_md("rand mult", 3'd0, ra, rb, sp, 5, 0);
            ua = ra; ub = rb;
            run_md("rand multu", 3'd1, ra, rb, ua * ub, 5, 0);
            rb = $urandom_range(1, 5000);
            run_md("rand divu", 3'd3, ra, rb, {ra % rb, ra / rb}, 10, 0);
        end

        // Asynchronous reset in the middle of a mult
        @(negedge clk);
        do_mt("mthi a5", 3'd4, 32'hA5);
        valid = 1'b1; op = 3'd0; a_in = 32'd5; b_in = 32'd5;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("midrun busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("async reset HI", hi, 0);
        chk("async reset LO", lo, 0);
        chk("async reset busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("after reset hilo", {hi, lo}, 0);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
